// File: rtl/vram_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_arbiter_if
// Brief    : CPU, config and VRAM port-A signal bundle for the write arbiter.
// Revision : 1.0
// ============================================================================
interface vram_write_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              cpu_vram_csn;
  logic              cpu_rw;
  logic              cpu_uds_n;
  logic              cpu_lds_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_dtack_n;

  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [15:0]       cfg_data;

  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic [1:0]        vram_be;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output cpu_vram_csn, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_dout,
    output cfg_we, cfg_addr, cfg_data,
    input  cpu_dtack_n, vram_we, vram_addr, vram_data, vram_be, fill_busy, fill_done
  );

  modport slave (
    input  cpu_vram_csn, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_dout,
    input  cfg_we, cfg_addr, cfg_data,
    output cpu_dtack_n, vram_we, vram_addr, vram_data, vram_be, fill_busy, fill_done
  );
endinterface
`default_nettype wire

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_arbiter
// Brief    : Shares VRAM port A between 68000 writes and a linear fill engine.
// Revision : 1.0
// ============================================================================
module vram_write_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vram_write_arbiter_if.slave  bus
);

  localparam int HI_W     = ADDR_W - 16;
  localparam int COLOUR_W = 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CPU_WR  = 2'd1,
    S_CPU_HLD = 2'd2,
    S_FILL    = 2'd3
  } state_t;

  state_t              state_q,    state_d;
  logic                dtack_n_q,  dtack_n_d;
  logic                we_q,       we_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   data_q,     data_d;
  logic [1:0]          be_q,       be_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [15:0]         start_lo_q, start_lo_d;
  logic [HI_W-1:0]     start_hi_q, start_hi_d;
  logic [15:0]         len_q,      len_d;
  logic [COLOUR_W-1:0] colour_q,   colour_d;
  logic [ADDR_W-1:0]   ptr_q,      ptr_d;
  logic [15:0]         rem_q,      rem_d;
  logic                w_fill_word;
  logic                w_fill_pending;

  assign w_fill_pending = busy_q && (rem_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dtack_n_q  <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_lo_q <= '0;
      start_hi_q <= '0;
      len_q      <= '0;
      colour_q   <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      dtack_n_q  <= dtack_n_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_lo_q <= start_lo_d;
      start_hi_q <= start_hi_d;
      len_q      <= len_d;
      colour_q   <= colour_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dtack_n_d   = 1'b1;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_lo_d  = start_lo_q;
    start_hi_d  = start_hi_q;
    len_d       = len_q;
    colour_d    = colour_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    w_fill_word = 1'b0;

    // CPU always wins; the fill only advances on cycles the CPU leaves free.
    case (state_q)
      S_IDLE, S_FILL: begin
        if (!bus.cpu_vram_csn) begin
          state_d = S_CPU_WR;
        end else if (w_fill_pending) begin
          state_d     = S_FILL;
          w_fill_word = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU_WR: begin
        state_d   = S_CPU_HLD;
        dtack_n_d = 1'b0;
      end
      S_CPU_HLD: begin
        if (!bus.cpu_vram_csn) begin
          dtack_n_d = 1'b0;
        end else if (w_fill_pending) begin
          state_d     = S_FILL;
          w_fill_word = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_CPU_WR) && !bus.cpu_rw) begin
      we_d   = 1'b1;
      addr_d = bus.cpu_addr;
      data_d = bus.cpu_dout;
      be_d   = {~bus.cpu_uds_n, ~bus.cpu_lds_n};
    end

    if (w_fill_word) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      data_d = {{(DATA_W-COLOUR_W){1'b0}}, colour_q};
      be_d   = 2'b11;
      ptr_d  = ptr_q + ADDR_W'(1);
      rem_d  = rem_q - 16'd1;
    end

    // Completion is one edge after the last word; a zero-length fill ends here directly.
    if (busy_q && (rem_q == '0)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (!busy_q && bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: start_lo_d = bus.cfg_data;
        2'd1: start_hi_d = bus.cfg_data[HI_W-1:0];
        2'd2: len_d      = bus.cfg_data;
        default: begin
          colour_d = bus.cfg_data[COLOUR_W-1:0];
          if (bus.cfg_data[15]) begin
            busy_d = 1'b1;
            ptr_d  = {start_hi_q, start_lo_q};
            rem_d  = len_q;
          end
        end
      endcase
    end
  end

  assign bus.cpu_dtack_n = dtack_n_q;
  assign bus.vram_we     = we_q;
  assign bus.vram_addr   = addr_q;
  assign bus.vram_data   = data_q;
  assign bus.vram_be     = be_q;
  assign bus.fill_busy   = busy_q;
  assign bus.fill_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_write_arbiter
// Brief    : Directed, table-driven bench for vram_write_arbiter with a VRAM model.
// Revision : 1.0
// ============================================================================
module tb_vram_write_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   we_count;
  int   done_count;

  logic [DATA_W-1:0] mem  [0:DEPTH-1];
  int                wcnt [0:DEPTH-1];
  logic [ADDR_W-1:0] addr_log[$];
  logic [DATA_W-1:0] data_log[$];

  vram_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: outputs are stable mid-cycle, so commit on the falling edge.
  always @(negedge clk) begin
    if (bus.vram_we) begin
      if (bus.vram_be[1]) mem[bus.vram_addr][15:8] = bus.vram_data[15:8];
      if (bus.vram_be[0]) mem[bus.vram_addr][7:0]  = bus.vram_data[7:0];
      wcnt[bus.vram_addr] = wcnt[bus.vram_addr] + 1;
      we_count = we_count + 1;
      addr_log.push_back(bus.vram_addr);
      data_log.push_back(bus.vram_data);
    end
    if (bus.fill_done) done_count = done_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.fill_done && n < max_cyc);
    check(name, bus.fill_done, 1);
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    @(negedge clk);
    bus.cpu_vram_csn = 1'b0;
    bus.cpu_rw       = 1'b0;
    bus.cpu_uds_n    = 1'b0;
    bus.cpu_lds_n    = 1'b0;
    bus.cpu_addr     = a;
    bus.cpu_dout     = d;
    n = 0;
    while (bus.cpu_dtack_n && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cpu_dtack_asserted", bus.cpu_dtack_n, 0);
    @(negedge clk);
    bus.cpu_vram_csn = 1'b1;
    bus.cpu_rw       = 1'b1;
    @(posedge clk);
    #1;
    check("cpu_dtack_released", bus.cpu_dtack_n, 1);
  endtask

  typedef struct {
    logic              rw;
    logic              uds_n;
    logic              lds_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              exp_we;
    logic [1:0]        exp_be;
    logic [DATA_W-1:0] exp_mem;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int wc0;
    int dc0;
    int bad;
    int fill_words;
    logic [ADDR_W-1:0] cpu_a [20];
    logic [DATA_W-1:0] cpu_d [20];

    checks     = 0;
    failures   = 0;
    we_count   = 0;
    done_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      wcnt[i] = 0;
    end

    // rw, uds_n, lds_n, addr, dout, exp_we, exp_be, exp_mem (VRAM starts zeroed)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 17'h00040, 16'h0ABC, 1'b1, 2'b11, 16'h0ABC};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 17'h00041, 16'h1234, 1'b1, 2'b01, 16'h0034};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 17'h1FFFF, 16'hBEEF, 1'b1, 2'b10, 16'hBE00};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 17'h00100, 16'h5555, 1'b0, 2'b00, 16'h0000};

    reset_n          = 1'b0;
    bus.cpu_vram_csn = 1'b1;
    bus.cpu_rw       = 1'b1;
    bus.cpu_uds_n    = 1'b1;
    bus.cpu_lds_n    = 1'b1;
    bus.cpu_addr     = '0;
    bus.cpu_dout     = '0;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_data     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dtack_n", bus.cpu_dtack_n, 1);
    check("rst_vram_we", bus.vram_we, 0);
    check("rst_vram_addr", bus.vram_addr, 0);
    check("rst_vram_data", bus.vram_data, 0);
    check("rst_vram_be", bus.vram_be, 0);
    check("rst_fill_busy", bus.fill_busy, 0);
    check("rst_fill_done", bus.fill_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU accesses: write/byte-write/read with exact DTACK timing
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wc0 = we_count;
      bus.cpu_vram_csn = 1'b0;
      bus.cpu_rw       = vecs[i].rw;
      bus.cpu_uds_n    = vecs[i].uds_n;
      bus.cpu_lds_n    = vecs[i].lds_n;
      bus.cpu_addr     = vecs[i].addr;
      bus.cpu_dout     = vecs[i].dout;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we_n", i), bus.vram_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i), bus.vram_addr, vecs[i].addr);
        check($sformatf("v%0d_data", i), bus.vram_data, vecs[i].dout);
        check($sformatf("v%0d_be", i), bus.vram_be, vecs[i].exp_be);
      end
      check($sformatf("v%0d_dtack_n_at_n", i), bus.cpu_dtack_n, 1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dtack_n_at_n1", i), bus.cpu_dtack_n, 0);
      check($sformatf("v%0d_we_n1", i), bus.vram_we, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dtack_n_held", i), bus.cpu_dtack_n, 0);
      @(negedge clk);
      bus.cpu_vram_csn = 1'b1;
      bus.cpu_rw       = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dtack_n_release", i), bus.cpu_dtack_n, 1);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_we_pulses", i), we_count - wc0, vecs[i].exp_we);
      check($sformatf("v%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_mem);
    end

    // Fill wrapping past the top of the address space
    cfg_write(2'd0, 16'hFFFE);
    cfg_write(2'd1, 16'h0001);
    cfg_write(2'd2, 16'd4);
    addr_log.delete();
    data_log.delete();
    dc0 = done_count;
    cfg_write(2'd3, 16'h80F0);
    check("wrap_busy_after_go", bus.fill_busy, 1);
    wait_done("wrap_done_seen", 50, n);
    check("wrap_done_latency", n, 5);
    check("wrap_busy_cleared", bus.fill_busy, 0);
    @(posedge clk);
    #1;
    check("wrap_done_one_cycle", bus.fill_done, 0);
    @(negedge clk);
    #1;
    check("wrap_word_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", addr_log[0], 17'h1FFFE);
      check("wrap_addr1", addr_log[1], 17'h1FFFF);
      check("wrap_addr2", addr_log[2], 17'h00000);
      check("wrap_addr3", addr_log[3], 17'h00001);
      check("wrap_data", data_log[3], 16'h00F0);
    end
    check("wrap_done_count", done_count - dc0, 1);

    // Zero-length fill
    cfg_write(2'd2, 16'd0);
    wc0 = we_count;
    dc0 = done_count;
    cfg_write(2'd3, 16'h8123);
    check("len0_busy_pulse", bus.fill_busy, 1);
    @(posedge clk);
    #1;
    check("len0_busy_cleared", bus.fill_busy, 0);
    check("len0_done", bus.fill_done, 1);
    @(posedge clk);
    #1;
    check("len0_done_one_cycle", bus.fill_done, 0);
    @(negedge clk);
    #1;
    check("len0_no_writes", we_count - wc0, 0);
    check("len0_done_count", done_count - dc0, 1);

    // Config writes while busy must be ignored
    cfg_write(2'd0, 16'h2000);
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'd50);
    addr_log.delete();
    data_log.delete();
    cfg_write(2'd3, 16'h8555);
    cfg_write(2'd3, 16'h8777);
    cfg_write(2'd2, 16'd5);
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd1, 16'h0001);
    wait_done("busy_done_seen", 200, n);
    @(negedge clk);
    #1;
    check("busy_word_count", addr_log.size(), 50);
    if (addr_log.size() == 50) begin
      check("busy_first_addr", addr_log[0], 17'h02000);
      check("busy_last_addr", addr_log[49], 17'h02031);
      check("busy_colour", data_log[49], 16'h0555);
    end
    addr_log.delete();
    data_log.delete();
    cfg_write(2'd3, 16'h8333);
    wait_done("regs_kept_done_seen", 200, n);
    @(negedge clk);
    #1;
    check("regs_kept_count", addr_log.size(), 50);
    if (addr_log.size() == 50) begin
      check("regs_kept_start", addr_log[0], 17'h02000);
      check("regs_kept_colour", data_log[0], 16'h0333);
    end

    // Long fill with interleaved CPU writes
    cfg_write(2'd0, 16'h3000);
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'd1000);
    addr_log.delete();
    data_log.delete();
    wc0 = we_count;
    dc0 = done_count;
    cfg_write(2'd3, 16'h8ABC);
    for (int i = 0; i < 20; i++) begin
      cpu_a[i] = 17'(32'h10000 + i * 13);
      cpu_d[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      repeat ($urandom_range(1, 25)) @(negedge clk);
      cpu_write(cpu_a[i], cpu_d[i]);
    end
    wait_done("mix_done_seen", 3000, n);
    @(negedge clk);
    #1;
    bad = 0;
    for (int a = 32'h3000; a < 32'h3000 + 1000; a++)
      if (wcnt[a] != 1 || mem[a] != 16'h0ABC) bad++;
    check("mix_fill_words_exactly_once", bad, 0);
    fill_words = 0;
    foreach (data_log[k]) if (data_log[k] == 16'h0ABC) fill_words++;
    check("mix_fill_cycle_count", fill_words, 1000);
    check("mix_total_writes", we_count - wc0, 1020);
    check("mix_done_count", done_count - dc0, 1);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (mem[cpu_a[i]] != cpu_d[i] || wcnt[cpu_a[i]] != 1) bad++;
    check("mix_cpu_writes_landed", bad, 0);

    // Reset in the middle of a fill
    cfg_write(2'd0, 16'h5000);
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'd100);
    dc0 = done_count;
    cfg_write(2'd3, 16'h8777);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.vram_we && bus.vram_addr == 17'h0500A) && n < 100);
    check("rstmid_reached_word10", bus.vram_addr, 17'h0500A);
    reset_n = 1'b0;
    #1;
    check("rstmid_dtack_n", bus.cpu_dtack_n, 1);
    check("rstmid_vram_we", bus.vram_we, 0);
    check("rstmid_vram_addr", bus.vram_addr, 0);
    check("rstmid_vram_data", bus.vram_data, 0);
    check("rstmid_vram_be", bus.vram_be, 0);
    check("rstmid_fill_busy", bus.fill_busy, 0);
    check("rstmid_fill_done", bus.fill_done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wc0 = we_count;
    repeat (20) @(negedge clk);
    #1;
    check("rstmid_no_done", done_count - dc0, 0);
    check("rstmid_no_more_writes", we_count - wc0, 0);
    check("rstmid_busy_after", bus.fill_busy, 0);
    check("rstmid_word9_written", mem[17'h05009], 16'h0777);
    bad = 0;
    for (int a = 32'h500A; a < 32'h5000 + 100; a++)
      if (mem[a] != 16'h0000) bad++;
    check("rstmid_words_10_99_untouched", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
